led_seq_ctrl: RTL and testbench

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

---
 rtl/led_pkg.sv | 9 +
 rtl/led_tick_gen.sv | 34 +++
 rtl/led_seq_ctrl.sv | 72 +++++++
 tb/tb_led_seq_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED sequencer and its pattern ROM: state codes and default widths.
package led_pkg;
    localparam int MEM_ADDR_DEF = 3;
    localparam int DIV_W_DEF    = 24;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_PAUSED = 2'd2;
endpackage

// File: rtl/led_tick_gen.sv
// Step-period prescaler: counts 0..div_q and flags the terminal count.
module led_tick_gen
    import led_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             hold,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_q;

    assign tick = (cnt == div_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            div_q <= '0;
        end else begin
            if (load)
                div_q <= div;
            // Counter self-clears on terminal count, so the owner never needs clear for an advance.
            if (clear)
                cnt <= '0;
            else if (!hold)
                cnt <= tick ? '0 : cnt + DIV_W'(1);
        end
    end
endmodule

// File: rtl/led_seq_ctrl.sv
// LED pattern sequencer: walks a ROM address up or down at a programmable rate with pause/step control.
module led_seq_ctrl
    import led_pkg::*;
#(
    parameter int MEM_ADDR = MEM_ADDR_DEF,
    parameter int DIV_W    = DIV_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                stop,
    input  logic                pause,
    input  logic                dir,
    input  logic                step,
    input  logic [DIV_W-1:0]    div,
    output logic [MEM_ADDR-1:0] addr,
    output logic                running,
    output logic                wrap
);
    logic [1:0]          state;
    logic                tick;
    logic                counting;
    logic                advance;
    logic                wrap_cond;
    logic [MEM_ADDR-1:0] addr_nxt;

    always_comb begin
        counting  = (state == ST_RUN) && !pause;
        advance   = !stop && !start &&
                    ((counting && tick) || ((state == ST_PAUSED) && pause && step));
        addr_nxt  = dir ? addr - MEM_ADDR'(1) : addr + MEM_ADDR'(1);
        wrap_cond = dir ? (addr == '0) : (addr == '1);
    end

    led_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (stop | start),
        .hold  (!counting),
        .load  (start & !stop),
        .div   (div),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            addr  <= '0;
            wrap  <= 1'b0;
        end else begin
            wrap <= advance && wrap_cond;
            if (stop) begin
                state <= ST_IDLE;
                addr  <= '0;
            end else if (start) begin
                state <= ST_RUN;
                addr  <= '0;
            end else begin
                if (advance)
                    addr <= addr_nxt;
                // Step is dropped on the resume edge because pause is already low there.
                case (state)
                    ST_RUN:    if (pause)  state <= ST_PAUSED;
                    ST_PAUSED: if (!pause) state <= ST_RUN;
                    default:   state <= ST_IDLE;
                endcase
            end
        end
    end

    assign running = (state == ST_RUN) || (state == ST_PAUSED);
endmodule

// File: tb/tb_led_seq_ctrl.sv
// Randomized and directed checks of led_seq_ctrl against a cycle-level behavioural model.
module tb_led_seq_ctrl;
    localparam int MEM_ADDR = 3;
    localparam int DIV_W    = 24;
    localparam int N        = 1 << MEM_ADDR;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0, stop = 1'b0, pause = 1'b0, dir = 1'b0, step = 1'b0;
    logic [DIV_W-1:0]    div = '0;
    logic [MEM_ADDR-1:0] addr;
    logic                running, wrap;

    int n_tests = 0;
    int n_fail  = 0;

    // model: mode 0 idle, 1 run, 2 paused
    int m_mode = 0, m_addr = 0, m_cnt = 0, m_divq = 0, m_wrap = 0;

    led_seq_ctrl #(.MEM_ADDR(MEM_ADDR), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .dir(dir), .step(step), .div(div), .addr(addr), .running(running), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic m_advance();
        if (!dir) begin
            if (m_addr == N - 1) m_wrap = 1;
            m_addr = (m_addr + 1) % N;
        end else begin
            if (m_addr == 0) m_wrap = 1;
            m_addr = (m_addr + N - 1) % N;
        end
    endtask

    task automatic m_update();
        m_wrap = 0;
        if (stop) begin
            m_mode = 0; m_addr = 0; m_cnt = 0;
        end else if (start) begin
            m_mode = 1; m_addr = 0; m_cnt = 0; m_divq = int'(div);
        end else if (m_mode == 1) begin
            if (pause) m_mode = 2;
            else if (m_cnt == m_divq) begin
                m_advance();
                m_cnt = 0;
            end else m_cnt++;
        end else if (m_mode == 2) begin
            if (!pause) m_mode = 1;
            else if (step) m_advance();
        end
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".addr"}, int'(addr), m_addr);
        chk({tag, ".running"}, int'(running), (m_mode != 0) ? 1 : 0);
        chk({tag, ".wrap"}, int'(wrap), m_wrap);
    endtask

    // inputs already set; clock one edge, update model, check away from the edge
    task automatic cyc(input string tag);
        @(posedge clk);
        m_update();
        #1;
        check_outs(tag);
        start = 1'b0; stop = 1'b0; step = 1'b0;
    endtask

    task automatic run_n(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag);
    endtask

    initial begin
        #12;
        check_outs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_outs("post_reset_idle");

        // div=3 counting up with wrap
        div = 24'd3; dir = 1'b0; start = 1'b1;
        cyc("s1_start");
        run_n("s1_up", 40);

        // div=0 counting down
        div = 24'd0; dir = 1'b1; start = 1'b1;
        cyc("s2_start");
        run_n("s2_down", 12);

        // pause at addr=2, cnt=1, three steps, resume
        div = 24'd3; dir = 1'b0; start = 1'b1;
        cyc("s3_start");
        for (int i = 0; i < 40 && !(m_addr == 2 && m_cnt == 1); i++) cyc("s3_seek");
        chk("s3_reached", (m_addr == 2 && m_cnt == 1) ? 1 : 0, 1);
        pause = 1'b1;
        cyc("s3_pause");
        for (int i = 0; i < 3; i++) begin
            step = 1'b1; cyc("s3_step");
            cyc("s3_gap");
        end
        chk("s3_stepped_addr", int'(addr), 5);
        pause = 1'b0; step = 1'b1;
        cyc("s3_resume");
        run_n("s3_run", 10);

        // stop and start together while running
        stop = 1'b1; start = 1'b1;
        cyc("s4_stop_start");
        run_n("s4_idle", 4);

        // div changes mid-run are ignored until next start
        div = 24'd3; dir = 1'b0; start = 1'b1;
        cyc("s6_start");
        div = 24'd1;
        run_n("s6_old_div", 12);
        start = 1'b1;
        cyc("s6_restart");
        run_n("s6_new_div", 8);

        // async reset between edges while addr=5
        for (int i = 0; i < 40 && m_addr != 5; i++) cyc("s5_seek");
        chk("s5_reached", m_addr, 5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_mode = 0; m_addr = 0; m_cnt = 0; m_divq = 0; m_wrap = 0;
        check_outs("s5_async");
        #2 rst_n = 1'b1;
        pause = 1'b1; step = 1'b1; dir = 1'b1;
        run_n("s5_stay_idle", 6);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 63) == 0);
            stop  = ($urandom_range(0, 127) == 0);
            if ($urandom_range(0, 7) == 0) pause = ~pause;
            if ($urandom_range(0, 15) == 0) dir = ~dir;
            step  = ($urandom_range(0, 2) == 0);
            div   = DIV_W'($urandom_range(0, 4));
            cyc("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
